// File: rtl/alarm_scheduler.sv
// alarm_scheduler: multi-slot BCD alarm matcher with ring/snooze/dismiss sequencing
module alarm_scheduler #(
   parameter int N_SLOTS    = 4,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic                       CP,
   input  logic                       _CR,
   input  logic                       tick_1hz,
   input  logic [7:0]                 show_hour,
   input  logic [7:0]                 show_min,
   input  logic [7:0]                 show_sec,
   input  logic                       active_alarm,
   input  logic                       wr_en,
   input  logic [$clog2(N_SLOTS)-1:0] wr_slot,
   input  logic [7:0]                 wr_hour,
   input  logic [7:0]                 wr_min,
   input  logic                       wr_arm,
   input  logic                       snooze,
   input  logic                       dismiss,
   input  logic [$clog2(N_SLOTS)-1:0] rd_slot,
   output logic [15:0]                rd_time,
   output logic [N_SLOTS-1:0]         slot_armed,
   output logic                       ring,
   output logic [$clog2(N_SLOTS)-1:0] ring_slot,
   output logic                       snoozing,
   output logic [N_SLOTS-1:0]         pending,
   output logic                       wr_err
);
   localparam int SW = $clog2(N_SLOTS);
   localparam int CW = $clog2(RING_SEC + 1);
   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
   state_t state;
   logic [7:0] slot_hour [N_SLOTS];
   logic [7:0] slot_min [N_SLOTS];
   logic [CW-1:0] ring_cnt;
   logic [15:0] tgt;
   logic match_ev, wr_ok, m_c, h_c;
   logic [N_SLOTS-1:0] match, wclr, serve;
   logic [SW-1:0] low_idx;
   logic [4:0] m_lo;
   logic [3:0] t_mlo, t_mhi;
   logic [7:0] t_hour;
   assign rd_time = {slot_hour[rd_slot], slot_min[rd_slot]};
   assign match_ev = tick_1hz && show_sec == 8'h00;
   assign wr_ok = wr_hour[3:0] <= 4'd9 && wr_hour <= 8'h23 && wr_min[7:4] <= 4'd5 && wr_min[3:0] <= 4'd9;
   assign wclr = (wr_en && wr_ok) ? N_SLOTS'(1) << wr_slot : '0;
   assign serve = (state == IDLE && |pending) ? N_SLOTS'(1) << low_idx : '0;
   always_comb begin
      match = '0;
      low_idx = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         match[i] = match_ev && active_alarm && slot_armed[i] && {slot_hour[i], slot_min[i]} == {show_hour, show_min};
         low_idx = pending[i] ? SW'(i) : low_idx;
      end
   end
   // snooze target: BCD minute add with carry into a 00..23 hour
   always_comb begin
      m_lo = {1'b0, show_min[3:0]} + 5'(SNOOZE_MIN);
      m_c = m_lo > 5'd9;
      t_mlo = m_c ? 4'(m_lo - 5'd10) : m_lo[3:0];
      h_c = m_c && show_min[7:4] == 4'd5;
      t_mhi = h_c ? 4'd0 : show_min[7:4] + 4'(m_c);
      t_hour = !h_c ? show_hour :
               show_hour == 8'h23 ? 8'h00 :
               show_hour[3:0] == 4'd9 ? {show_hour[7:4] + 4'd1, 4'd0} :
               {show_hour[7:4], show_hour[3:0] + 4'd1};
   end
   always_ff @(posedge CP) begin
      if (!_CR) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            slot_hour[i] <= '0;
            slot_min[i] <= '0;
         end
         slot_armed <= '0;
         state <= IDLE;
         ring <= 1'b0;
         snoozing <= 1'b0;
         ring_slot <= '0;
         pending <= '0;
         wr_err <= 1'b0;
         ring_cnt <= '0;
         tgt <= '0;
      end else begin
         wr_err <= wr_en && !wr_ok;
         if (wr_en && wr_ok) begin
            slot_hour[wr_slot] <= wr_hour;
            slot_min[wr_slot] <= wr_min;
            slot_armed[wr_slot] <= wr_arm;
         end
         if (!active_alarm) begin
            state <= IDLE;
            ring <= 1'b0;
            snoozing <= 1'b0;
            pending <= '0;
         end else begin
            pending <= (pending & ~(wclr | serve)) | match;
            case (state)
               IDLE: if (|pending) begin
                  state <= RING;
                  ring <= 1'b1;
                  ring_slot <= low_idx;
                  ring_cnt <= '0;
               end
               RING: if (dismiss) begin
                  state <= IDLE;
                  ring <= 1'b0;
               end else if (snooze) begin
                  state <= SNOOZE;
                  ring <= 1'b0;
                  snoozing <= 1'b1;
                  tgt <= {t_hour, t_mhi, t_mlo};
               end else if (tick_1hz) begin
                  if (ring_cnt == CW'(RING_SEC - 1)) begin
                     state <= IDLE;
                     ring <= 1'b0;
                  end else
                     ring_cnt <= ring_cnt + 1'b1;
               end
               SNOOZE: if (dismiss) begin
                  state <= IDLE;
                  snoozing <= 1'b0;
               end else if (match_ev && {show_hour, show_min} == tgt) begin
                  state <= RING;
                  ring <= 1'b1;
                  snoozing <= 1'b0;
                  ring_cnt <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: scenario tasks checked against a minute-of-day reference model
module tb_alarm_scheduler;
   localparam int SNOOZE = 5;
   logic CP = 1'b0, _CR, tick_1hz, active_alarm, wr_en, wr_arm, snooze, dismiss;
   logic [7:0] show_hour, show_min, show_sec, wr_hour, wr_min;
   logic [1:0] wr_slot, rd_slot, ring_slot;
   logic [15:0] rd_time;
   logic [3:0] slot_armed, pending;
   logic ring, snoozing, wr_err;
   int n_chk = 0, n_fail = 0;

   alarm_scheduler #(.N_SLOTS(4), .RING_SEC(60), .SNOOZE_MIN(SNOOZE)) dut (
      .CP(CP), ._CR(_CR), .tick_1hz(tick_1hz), .show_hour(show_hour), .show_min(show_min),
      .show_sec(show_sec), .active_alarm(active_alarm), .wr_en(wr_en), .wr_slot(wr_slot),
      .wr_hour(wr_hour), .wr_min(wr_min), .wr_arm(wr_arm), .snooze(snooze), .dismiss(dismiss),
      .rd_slot(rd_slot), .rd_time(rd_time), .slot_armed(slot_armed), .ring(ring),
      .ring_slot(ring_slot), .snoozing(snoozing), .pending(pending), .wr_err(wr_err));

   always #5 CP = ~CP;

   function automatic logic [7:0] bcd(int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic bit digits_ok(logic [7:0] b, int max);
      return b[7:4] <= 9 && b[3:0] <= 9 && (int'(b[7:4]) * 10 + int'(b[3:0])) <= max;
   endfunction

   task automatic cyc(int n);
      repeat (n) @(posedge CP);
      #1;
   endtask

   task automatic set_time(int h, int m, int s);
      show_hour = bcd(h);
      show_min = bcd(m);
      show_sec = bcd(s);
   endtask

   task automatic tick_at(int h, int m, int s = 0);
      set_time(h, m, s);
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
   endtask

   task automatic write_slot(int s, logic [7:0] h, logic [7:0] m, logic a);
      wr_en = 1'b1;
      wr_slot = 2'(s);
      wr_hour = h;
      wr_min = m;
      wr_arm = a;
      cyc(1);
      wr_en = 1'b0;
   endtask

   task automatic pulse_dismiss();
      dismiss = 1'b1;
      cyc(1);
      dismiss = 1'b0;
   endtask

   task automatic do_reset();
      _CR = 1'b0;
      {tick_1hz, wr_en, wr_arm, snooze, dismiss} = '0;
      active_alarm = 1'b1;
      {wr_slot, rd_slot, wr_hour, wr_min} = '0;
      set_time(0, 0, 30);
      cyc(2);
      _CR = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (ring !== 1'b0) begin n_fail++; $display("FAIL reset_ring: got %b want 0", ring); end
      n_chk++; if (snoozing !== 1'b0) begin n_fail++; $display("FAIL reset_snoozing: got %b want 0", snoozing); end
      n_chk++; if (ring_slot !== 2'd0) begin n_fail++; $display("FAIL reset_ring_slot: got %0d want 0", ring_slot); end
      n_chk++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
      n_chk++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
      n_chk++; if (slot_armed !== 4'd0) begin n_fail++; $display("FAIL reset_armed: got %b want 0000", slot_armed); end
      for (int j = 0; j < 4; j++) begin
         rd_slot = 2'(j);
         #1;
         n_chk++; if (rd_time !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_time[%0d]: got %h want 0000", j, rd_time); end
      end
   endtask

   task automatic test_single_ring();
      int s, o, t, pm;
      for (int k = 0; k < 3; k++) begin
         do_reset();
         s = k == 0 ? 1 : $urandom_range(0, 3);
         t = k == 0 ? 7 * 60 + 30 : $urandom_range(0, 1439);
         o = (s + 1) % 4;
         pm = (t + 1439) % 1440;
         write_slot(s, bcd(t / 60), bcd(t % 60), 1'b1);
         write_slot(o, bcd(t / 60), bcd(t % 60), 1'b0);
         tick_at(pm / 60, pm % 60, 59);
         n_chk++; if (pending !== 4'd0) begin n_fail++; $display("FAIL single_pre_pending: got %b want 0000", pending); end
         tick_at(t / 60, t % 60);
         n_chk++; if (pending !== 4'(1 << s) || ring !== 1'b0) begin n_fail++; $display("FAIL single_lat1: pending %b ring %b want %b/0", pending, ring, 4'(1 << s)); end
         cyc(1);
         n_chk++; if (ring !== 1'b1 || ring_slot !== 2'(s)) begin n_fail++; $display("FAIL single_ring: ring %b slot %0d want 1/%0d", ring, ring_slot, s); end
         n_chk++; if (pending !== 4'd0) begin n_fail++; $display("FAIL single_pending: got %b want 0000", pending); end
         pulse_dismiss();
         n_chk++; if (ring !== 1'b0) begin n_fail++; $display("FAIL single_dismiss: got %b want 0", ring); end
      end
   endtask

   task automatic test_simultaneous();
      int q[$];
      int t;
      logic [3:0] mask, rem;
      for (int k = 0; k < 3; k++) begin
         do_reset();
         t = k == 0 ? 6 * 60 : $urandom_range(0, 1439);
         if (k == 0) mask = 4'b0101;
         else do mask = 4'($urandom_range(0, 15)); while ($countones(mask) < 2);
         q.delete();
         for (int i = 0; i < 4; i++) if (mask[i]) begin
            q.push_back(i);
            write_slot(i, bcd(t / 60), bcd(t % 60), 1'b1);
         end
         rem = mask;
         tick_at(t / 60, t % 60);
         cyc(1);
         rem[q[0]] = 1'b0;
         n_chk++; if (ring !== 1'b1 || ring_slot !== 2'(q[0]) || pending !== rem) begin n_fail++; $display("FAIL simul_first: ring %b slot %0d pend %b want 1/%0d/%b", ring, ring_slot, pending, q[0], rem); end
         void'(q.pop_front());
         while (q.size() > 0) begin
            pulse_dismiss();
            n_chk++; if (ring !== 1'b0) begin n_fail++; $display("FAIL simul_gap: ring %b want 0", ring); end
            cyc(1);
            rem[q[0]] = 1'b0;
            n_chk++; if (ring !== 1'b1 || ring_slot !== 2'(q[0]) || pending !== rem) begin n_fail++; $display("FAIL simul_next: ring %b slot %0d pend %b want 1/%0d/%b", ring, ring_slot, pending, q[0], rem); end
            void'(q.pop_front());
         end
         pulse_dismiss();
         n_chk++; if (ring !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL simul_end: ring %b pend %b want 0/0000", ring, pending); end
      end
   endtask

   task automatic test_snooze();
      int t[3];
      int s, tg, pre;
      t = '{23 * 60 + 57, 10 * 60 + 59, $urandom_range(0, 1439)};
      for (int k = 0; k < 3; k++) begin
         do_reset();
         s = k == 0 ? 3 : $urandom_range(0, 3);
         write_slot(s, bcd(t[k] / 60), bcd(t[k] % 60), 1'b1);
         tick_at(t[k] / 60, t[k] % 60);
         cyc(1);
         snooze = 1'b1;
         cyc(1);
         snooze = 1'b0;
         n_chk++; if (snoozing !== 1'b1 || ring !== 1'b0 || ring_slot !== 2'(s)) begin n_fail++; $display("FAIL snooze_enter: snz %b ring %b slot %0d want 1/0/%0d", snoozing, ring, ring_slot, s); end
         tg = (t[k] + SNOOZE) % 1440;
         pre = (tg + 1439) % 1440;
         tick_at(pre / 60, pre % 60);
         cyc(1);
         n_chk++; if (snoozing !== 1'b1 || ring !== 1'b0) begin n_fail++; $display("FAIL snooze_early: snz %b ring %b want 1/0", snoozing, ring); end
         tick_at(tg / 60, tg % 60);
         n_chk++; if (ring !== 1'b1 || snoozing !== 1'b0 || ring_slot !== 2'(s)) begin n_fail++; $display("FAIL snooze_return: ring %b snz %b slot %0d want 1/0/%0d (target %0d)", ring, snoozing, ring_slot, s, tg); end
      end
   endtask

   task automatic test_timeout();
      int s, t, tg;
      do_reset();
      s = $urandom_range(0, 3);
      t = $urandom_range(0, 1439);
      write_slot(s, bcd(t / 60), bcd(t % 60), 1'b1);
      tick_at(t / 60, t % 60);
      cyc(1);
      for (int k = 1; k <= 60; k++) begin
         tick_at(t / 60, t % 60, 1);
         if (k == 59) begin
            n_chk++; if (ring !== 1'b1) begin n_fail++; $display("FAIL timeout_59: ring %b want 1", ring); end
         end
         if (k < 60) cyc(1);
      end
      n_chk++; if (ring !== 1'b0 || snoozing !== 1'b0) begin n_fail++; $display("FAIL timeout_60: ring %b snz %b want 0/0", ring, snoozing); end
      tick_at(t / 60, t % 60);
      cyc(1);
      n_chk++; if (ring !== 1'b1) begin n_fail++; $display("FAIL timeout_rering: ring %b want 1", ring); end
      snooze = 1'b1;
      dismiss = 1'b1;
      cyc(1);
      {snooze, dismiss} = '0;
      n_chk++; if (ring !== 1'b0 || snoozing !== 1'b0) begin n_fail++; $display("FAIL both_dismiss: ring %b snz %b want 0/0", ring, snoozing); end
      tg = (t + SNOOZE) % 1440;
      tick_at(tg / 60, tg % 60);
      cyc(1);
      n_chk++; if (ring !== 1'b0) begin n_fail++; $display("FAIL both_no_snooze: ring %b want 0", ring); end
   endtask

   task automatic test_write_err();
      logic [7:0] mh[4], mm[4], h, m;
      logic [3:0] ma;
      logic a;
      int s;
      bit ok;
      do_reset();
      for (int i = 0; i < 4; i++) begin mh[i] = 8'h00; mm[i] = 8'h00; end
      ma = '0;
      for (int k = 0; k < 24; k++) begin
         s = $urandom_range(0, 3);
         h = k == 0 ? 8'h24 : k == 1 ? 8'h07 : $urandom_range(0, 1) ? bcd($urandom_range(0, 23)) : 8'($urandom);
         m = k == 0 ? 8'h10 : k == 1 ? 8'h5A : $urandom_range(0, 1) ? bcd($urandom_range(0, 59)) : 8'($urandom);
         a = 1'($urandom);
         ok = digits_ok(h, 23) && digits_ok(m, 59);
         write_slot(s, h, m, a);
         n_chk++; if (wr_err !== !ok) begin n_fail++; $display("FAIL wr_err: %h:%h got %b want %b", h, m, wr_err, !ok); end
         if (ok) begin mh[s] = h; mm[s] = m; ma[s] = a; end
         cyc(1);
         n_chk++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
         n_chk++; if (slot_armed !== ma) begin n_fail++; $display("FAIL wr_armed: got %b want %b", slot_armed, ma); end
         for (int j = 0; j < 4; j++) begin
            rd_slot = 2'(j);
            #1;
            n_chk++; if (rd_time !== {mh[j], mm[j]}) begin n_fail++; $display("FAIL wr_rd_time[%0d]: got %h want %h", j, rd_time, {mh[j], mm[j]}); end
         end
      end
      do_reset();
      s = $urandom_range(0, 3);
      write_slot(s, 8'h12, 8'h34, 1'b1);
      tick_at(12, 34);
      cyc(1);
      write_slot(s, 8'h05, 8'h06, 1'b0);
      rd_slot = 2'(s);
      #1;
      n_chk++; if (ring !== 1'b1 || ring_slot !== 2'(s)) begin n_fail++; $display("FAIL wr_ringing: ring %b slot %0d want 1/%0d", ring, ring_slot, s); end
      n_chk++; if (rd_time !== 16'h0506) begin n_fail++; $display("FAIL wr_ringing_rd: got %h want 0506", rd_time); end
   endtask

   task automatic test_back_to_back();
      int s, t;
      do_reset();
      s = $urandom_range(0, 3);
      t = $urandom_range(0, 1439);
      write_slot(s, bcd(t / 60), bcd(t % 60), 1'b1);
      tick_at(t / 60, t % 60);
      cyc(1);
      tick_at(t / 60, t % 60);
      n_chk++; if (pending !== 4'(1 << s) || ring !== 1'b1 || ring_slot !== 2'(s)) begin n_fail++; $display("FAIL rematch: pend %b ring %b slot %0d want %b/1/%0d", pending, ring, ring_slot, 4'(1 << s), s); end
      pulse_dismiss();
      n_chk++; if (ring !== 1'b0) begin n_fail++; $display("FAIL rematch_gap: ring %b want 0", ring); end
      cyc(1);
      n_chk++; if (ring !== 1'b1 || ring_slot !== 2'(s) || pending !== 4'd0) begin n_fail++; $display("FAIL rematch_serve: ring %b slot %0d pend %b want 1/%0d/0000", ring, ring_slot, pending, s); end
      pulse_dismiss();
      snooze = 1'b1;
      cyc(1);
      snooze = 1'b0;
      n_chk++; if (snoozing !== 1'b0 || ring !== 1'b0) begin n_fail++; $display("FAIL idle_snooze: snz %b ring %b want 0/0", snoozing, ring); end
   endtask

   task automatic test_active_drop();
      int a, b, t;
      do_reset();
      a = $urandom_range(0, 2);
      b = $urandom_range(a + 1, 3);
      t = $urandom_range(0, 1439);
      write_slot(a, bcd(t / 60), bcd(t % 60), 1'b1);
      write_slot(b, bcd(t / 60), bcd(t % 60), 1'b1);
      tick_at(t / 60, t % 60);
      cyc(1);
      n_chk++; if (ring !== 1'b1 || pending !== 4'(1 << b)) begin n_fail++; $display("FAIL drop_pre: ring %b pend %b want 1/%b", ring, pending, 4'(1 << b)); end
      active_alarm = 1'b0;
      cyc(1);
      n_chk++; if (ring !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL drop: ring %b pend %b want 0/0000", ring, pending); end
      active_alarm = 1'b1;
      cyc(3);
      rd_slot = 2'(a);
      #1;
      n_chk++; if (ring !== 1'b0) begin n_fail++; $display("FAIL drop_after: ring %b want 0", ring); end
      n_chk++; if (slot_armed !== 4'((1 << a) | (1 << b)) || rd_time !== {bcd(t / 60), bcd(t % 60)}) begin n_fail++; $display("FAIL drop_kept: armed %b time %h", slot_armed, rd_time); end
   endtask

   task automatic test_reset_snooze();
      do_reset();
      write_slot(3, 8'h09, 8'h15, 1'b1);
      tick_at(9, 15);
      cyc(1);
      snooze = 1'b1;
      cyc(1);
      snooze = 1'b0;
      tick_at(9, 15);
      n_chk++; if (snoozing !== 1'b1 || pending !== 4'b1000) begin n_fail++; $display("FAIL rst_pre: snz %b pend %b want 1/1000", snoozing, pending); end
      _CR = 1'b0;
      cyc(1);
      _CR = 1'b1;
      rd_slot = 2'd3;
      #1;
      n_chk++; if ({ring, snoozing, wr_err} !== 3'b000 || ring_slot !== 2'd0 || pending !== 4'd0) begin n_fail++; $display("FAIL rst_mid: ring %b snz %b err %b slot %0d pend %b", ring, snoozing, wr_err, ring_slot, pending); end
      n_chk++; if (slot_armed !== 4'd0 || rd_time !== 16'h0000) begin n_fail++; $display("FAIL rst_slots: armed %b time %h", slot_armed, rd_time); end
   endtask

   initial begin
      test_reset();
      test_single_ring();
      test_simultaneous();
      test_snooze();
      test_timeout();
      test_write_err();
      test_back_to_back();
      test_active_drop();
      test_reset_snooze();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Multi-slot alarm controller for the digital clock. It holds N_SLOTS programmable BCD alarm times and compares them against the running hour/min/sec counters on each 1 Hz tick. It arbitrates simultaneous matches, then sequences ring, snooze and dismiss, and drives a single ring request to the reminder/light logic. It sits between the time counters, the select/adjust path that programs the slots, and the reminder block.

Parameters:
N_SLOTS, 4, number of alarm slots (slot index width 2)
RING_SEC, 60, ticks a ring lasts without user action before auto-dismiss
SNOOZE_MIN, 5, snooze delay in minutes (1..9)

Ports:
CP  in  1  system clock (100 MHz)
_CR  in  1  synchronous active-low reset
tick_1hz  in  1  one-CP-cycle pulse, once per second
show_hour  in  8  current hour, BCD 00..23
show_min  in  8  current minute, BCD 00..59
show_sec  in  8  current second, BCD 00..59
active_alarm  in  1  global alarm enable
wr_en  in  1  slot write strobe
wr_slot  in  2  slot to write
wr_hour  in  8  BCD hour to store
wr_min  in  8  BCD minute to store
wr_arm  in  1  armed bit to store
snooze  in  1  one-cycle pulse, debounced upstream
dismiss  in  1  one-cycle pulse, debounced upstream
rd_slot  in  2  slot selected for readback
rd_time  out  16  {hour,min} of rd_slot, combinational
slot_armed  out  4  armed bit per slot
ring  out  1  alarm sounding
ring_slot  out  2  slot that owns the current ring or snooze
snoozing  out  1  in SNOOZE state
pending  out  4  matched slots waiting for service
wr_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (_CR=0 at a CP edge): all slots 00:00 and disarmed; state IDLE; ring=0, snoozing=0, ring_slot=0, pending=0, wr_err=0; internal counters cleared.
- All state updates on the CP rising edge only.
- Slot write: on wr_en, hour must be <=0x23 and minute <=0x59 with each nibble <=9.
  - Invalid: no change to the slot; wr_err=1 for one cycle.
  - Valid: slot updated next cycle and its pending bit cleared. The current ring/snooze is unaffected, even if it is the written slot.
- Match event: tick_1hz=1 and show_sec==8'h00. For each slot, slot armed, slot time equal to {show_hour,show_min}, and active_alarm=1 sets its pending bit.
- FSM states: IDLE, RING, SNOOZE.
  - IDLE: when pending!=0, go to RING on the next edge. ring_slot is the lowest set pending index, whose pending bit is cleared. ring=1 is asserted in the cycle after pending is set, so latency is 2 CP cycles from the match tick.
  - RING: ring_cnt increments on each tick.
    - dismiss: go to IDLE.
    - snooze: go to SNOOZE and latch the target = current time + SNOOZE_MIN minutes in BCD. Minute wrap 59->00 carries to the hour; hour 23->00.
    - ring_cnt reaching RING_SEC: go to IDLE (auto-dismiss).
    - ring_cnt clears on entry to RING.
  - SNOOZE: ring=0, snoozing=1.
    - Match event against the target time returns to RING with the same ring_slot.
    - dismiss: go to IDLE.
- Priority in one cycle: _CR, then active_alarm=0, then dismiss, then snooze, then tick/timeout. dismiss and snooze together act as dismiss.
- active_alarm=0: force IDLE and clear pending in that cycle. Slot contents and armed bits are kept.
- Matches arriving while in RING or SNOOZE are latched in pending and served in index order after return to IDLE. There is one IDLE cycle between consecutive rings.
- snooze or dismiss while in IDLE: ignored.
- A slot re-matching while it owns the ring: pending bit set and served later. No double ring.

Test Plan:
- Reset, write slot1=07:30 armed, drive time 07:29:59 then tick to 07:30:00 -> ring=1 with ring_slot=1 exactly 2 CP cycles after the tick; pending=0.
- Slots 0 and 2 both 06:00 armed, tick at 06:00:00 -> ring_slot=0 and pending=4'b0100. After dismiss: one IDLE cycle, then ring=1 with ring_slot=2.
- Slot3=23:57 ringing, snooze -> snoozing=1, target 00:02. Tick at 00:02:00 -> ring=1, ring_slot=3. Also check 10:59 + 5 gives 11:04.
- Ring with no action for 60 ticks -> ring=0 and state IDLE on the 60th tick. Snooze and dismiss asserted in the same cycle -> IDLE, no snooze.
- Write hour=8'h24 or min=8'h5A -> wr_err pulses for 1 cycle and rd_time is unchanged. Write to the ringing slot -> ring stays 1.
- active_alarm dropped during RING with pending!=0 -> ring=0 and pending=0 next cycle. Assert _CR=0 mid-SNOOZE -> all outputs return to their reset values on the next edge.
